booth_seq_encoder: RTL

Sequential radix-4 Booth encoder for the Wallace-tree multiplier datapath. It is the producer that drives the partial-product generator's one-hot select inputs (zero/one/two/neg1/neg2).
- Accepts one multiplier operand B through a valid/ready handshake.
- Emits one Booth group per cycle, with group index and last flag, over a second valid/ready handshake.
- The generator consumes each group to form one 66-bit partial product.

---
 rtl/mul_booth_pkg.sv | 27 ++
 rtl/booth_group_enc.sv | 22 ++
 rtl/booth_seq_encoder.sv | 129 ++++++++++++
 3 files changed

// File: rtl/mul_booth_pkg.sv
// Shared radix-4 Booth constants and select encoding for the multiplier datapath.
package mul_booth_pkg;

  localparam int BOOTH_WIDTH = 32;
  localparam int BOOTH_NGRP  = BOOTH_WIDTH / 2 + 1;
  localparam int BOOTH_IDX_W = $clog2(BOOTH_NGRP);

  typedef enum logic [2:0] {
    SEL_ZERO,
    SEL_ONE,
    SEL_TWO,
    SEL_NEG1,
    SEL_NEG2
  } sel_e;

  // Triplet is {b[2i+1], b[2i], b[2i-1]}.
  function automatic sel_e booth_decode(input logic [2:0] trip);
    case (trip)
      3'b001, 3'b010: booth_decode = SEL_ONE;
      3'b011:         booth_decode = SEL_TWO;
      3'b100:         booth_decode = SEL_NEG2;
      3'b101, 3'b110: booth_decode = SEL_NEG1;
      default:        booth_decode = SEL_ZERO;
    endcase
  endfunction

endpackage

// File: rtl/booth_group_enc.sv
// Combinational Booth triplet to one-hot select decoder (zero/+A/+2A/-A/-2A).
module booth_group_enc
  import mul_booth_pkg::*;
(
  input  logic [2:0] trip,
  output logic       zero,
  output logic       one,
  output logic       two,
  output logic       neg1,
  output logic       neg2
);

  sel_e sel;

  assign sel  = booth_decode(trip);
  assign zero = (sel == SEL_ZERO);
  assign one  = (sel == SEL_ONE);
  assign two  = (sel == SEL_TWO);
  assign neg1 = (sel == SEL_NEG1);
  assign neg2 = (sel == SEL_NEG2);

endmodule

// File: rtl/booth_seq_encoder.sv
// Sequential radix-4 Booth encoder: one operand in, one Booth group out per handshake.
// BOOTH_SKIP_ZERO_EN: suppress zero groups, enc_last marks the last non-zero group.
module booth_seq_encoder
  import mul_booth_pkg::*;
#(
  parameter int WIDTH = BOOTH_WIDTH,
  parameter int NGRP  = WIDTH / 2 + 1,
  parameter int IDX_W = $clog2(NGRP)
) (
  input  logic             mul_clk,
  input  logic             resetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] b_in,
  input  logic             signed_op,
  output logic             enc_valid,
  input  logic             enc_ready,
  output logic             zero,
  output logic             one,
  output logic             two,
  output logic             neg1,
  output logic             neg2,
  output logic [IDX_W-1:0] enc_idx,
  output logic             enc_last
);

  // Shift register holds bits WIDTH+1 .. -1 of the extended operand.
  localparam int SRW = WIDTH + 3;

  typedef enum logic {IDLE, ENC} state_e;

  state_e           state;
  logic [SRW-1:0]   sr;
  logic             ext_hi;
  logic [SRW-1:0]   ext;
  logic             fire;
  logic             load;
  logic             last_c;
  logic [SRW-1:0]   load_sr;
  logic [SRW-1:0]   adv_sr;
  logic [IDX_W-1:0] load_idx;
  logic [IDX_W-1:0] adv_idx;

  assign ext_hi    = signed_op & b_in[WIDTH-1];
  assign ext       = {ext_hi, ext_hi, b_in, 1'b0};
  assign enc_valid = (state == ENC);
  assign fire      = enc_valid & enc_ready;
  assign enc_last  = enc_valid & last_c;
  assign in_ready  = (state == IDLE) | (fire & last_c);
  assign load      = in_valid & in_ready;

`ifdef BOOTH_SKIP_ZERO_EN
  localparam logic [IDX_W:0] NGRP_V = (IDX_W + 1)'(NGRP);

  // Sign-filling shift keeps vacated groups decoding as zero.
  function automatic logic [SRW-1:0] asr(input logic [SRW-1:0] v, input logic [IDX_W:0] n);
    asr = $signed(v) >>> (2 * n);
  endfunction

  // Position of the first non-zero group, NGRP_V when none remain.
  function automatic logic [IDX_W:0] first_nz(input logic [SRW-1:0] v);
    logic [IDX_W:0] r;
    r = NGRP_V;
    for (int g = NGRP - 1; g >= 0; g--) begin
      if (!((v[2*g] == v[2*g+1]) && (v[2*g+1] == v[2*g+2]))) r = (IDX_W + 1)'(g);
    end
    return r;
  endfunction

  logic [IDX_W:0] load_j;
  logic [IDX_W:0] adv_k;
  logic [SRW-1:0] sr_nxt;

  always_comb begin
    load_j = first_nz(ext);
    sr_nxt = asr(sr, (IDX_W + 1)'(1));
    adv_k  = first_nz(sr_nxt);
    last_c = (adv_k == NGRP_V);
    if (load_j == NGRP_V) begin
      load_sr  = ext;
      load_idx = '0;
    end else begin
      load_sr  = asr(ext, load_j);
      load_idx = load_j[IDX_W-1:0];
    end
    adv_sr  = asr(sr_nxt, adv_k);
    adv_idx = enc_idx + IDX_W'(1) + adv_k[IDX_W-1:0];
  end
`else
  always_comb begin
    last_c   = (enc_idx == IDX_W'(NGRP - 1));
    load_sr  = ext;
    load_idx = '0;
    adv_sr   = {sr[SRW-1], sr[SRW-1], sr[SRW-1:2]};
    adv_idx  = enc_idx + IDX_W'(1);
  end
`endif

  always_ff @(posedge mul_clk or negedge resetn) begin
    if (!resetn) begin
      state   <= IDLE;
      sr      <= '0;
      enc_idx <= '0;
    end else if (load) begin
      state   <= ENC;
      sr      <= load_sr;
      enc_idx <= load_idx;
    end else if (fire) begin
      if (last_c) begin
        state   <= IDLE;
        sr      <= '0;
        enc_idx <= '0;
      end else begin
        sr      <= adv_sr;
        enc_idx <= adv_idx;
      end
    end
  end

  booth_group_enc u_dec (
    .trip (sr[2:0]),
    .zero (zero),
    .one  (one),
    .two  (two),
    .neg1 (neg1),
    .neg2 (neg2)
  );

endmodule
